// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : op and FSM state encodings shared by the shift sequencer files.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_OP_SLL = 2'b00,
    SHIFT_OP_SRL = 2'b01,
    SHIFT_OP_SRA = 2'b10,
    SHIFT_OP_RSV = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// shift_step : one narrow shift step (0..2**STEP_BITS-1 bits).
//              Sign fill exists only when SHIFT_SEQ_SRA_EN is defined.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int NUM_SIZE  = 32,
  parameter int STEP_BITS = 3
) (
  input  logic [NUM_SIZE-1:0]  dIn,
  input  logic [1:0]           op,
  input  logic [STEP_BITS-1:0] step,
  input  logic                 signBit,
  output logic [NUM_SIZE-1:0]  dOut
);

`ifndef SHIFT_SEQ_SRA_EN
  logic unused_sign;
  assign unused_sign = signBit;
`endif

  always_comb begin
    dOut = '0;
    case (op)
      SHIFT_OP_SLL: dOut = dIn << step;
`ifdef SHIFT_SEQ_SRA_EN
      // Extend by the held sign bit so the fill is independent of dIn's MSB.
      SHIFT_OP_SRA: dOut = NUM_SIZE'($signed({signBit, dIn}) >>> step);
`endif
      default:      dOut = dIn >> step;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// shift_sequencer : multi-cycle SLL/SRL/SRA using a narrow per-cycle shifter.
//                   Optional arithmetic shift via SHIFT_SEQ_SRA_EN.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module shift_sequencer
  import shift_pkg::*;
#(
  parameter int NUM_SIZE  = 32,
  parameter int STEP_BITS = 3
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic [1:0]                  reqOp,
  input  logic [NUM_SIZE-1:0]         reqData,
  input  logic [$clog2(NUM_SIZE)-1:0] reqShamt,
  output logic                        rspValid,
  input  logic                        rspReady,
  output logic [NUM_SIZE-1:0]         rspData,
  output logic                        busy
);

  localparam int SW       = $clog2(NUM_SIZE);
  localparam int STEP_MAX = 2**STEP_BITS - 1;

  state_e                state, state_nxt;
  logic [NUM_SIZE-1:0]   data_q;
  logic [NUM_SIZE-1:0]   step_out;
  logic [SW-1:0]         remaining_q;
  logic [1:0]            op_q;
  logic [STEP_BITS-1:0]  step;
  logic                  accept;
  logic                  last_step;
  logic                  sign_bit;

  assign accept    = reqValid & reqReady;
  assign last_step = (remaining_q <= SW'(STEP_MAX));
  assign step      = last_step ? remaining_q[STEP_BITS-1:0] : STEP_BITS'(STEP_MAX);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    reqReady  = 1'b0;
    rspValid  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        reqReady = 1'b1;
        busy     = 1'b0;
        if (reqValid) state_nxt = (reqShamt == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        rspValid = 1'b1;
        if (rspReady) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rspData = rspValid ? data_q : '0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      data_q      <= '0;
      remaining_q <= '0;
      op_q        <= '0;
    end else if (accept) begin
      data_q      <= reqData;
      remaining_q <= reqShamt;
      op_q        <= reqOp;
    end else if (state == S_SHIFT) begin
      data_q      <= step_out;
      remaining_q <= remaining_q - SW'(step);
    end
  end

`ifdef SHIFT_SEQ_SRA_EN
  logic sign_q;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)       sign_q <= 1'b0;
    else if (accept) sign_q <= reqData[NUM_SIZE-1];
  end
  assign sign_bit = sign_q;
`else
  assign sign_bit = 1'b0;
`endif

  shift_step #(
    .NUM_SIZE  (NUM_SIZE),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .dIn     (data_q),
    .op      (op_q),
    .step    (step),
    .signBit (sign_bit),
    .dOut    (step_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// tb_shift_sequencer : directed and randomised checks of shift_sequencer.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [31:0] reqData;
  logic [4:0]  reqShamt;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.NUM_SIZE(32), .STEP_BITS(3)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqOp    (reqOp),
    .reqData  (reqData),
    .reqShamt (reqShamt),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspData  (rspData),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] sh);
    case (op)
      2'b00: ref_shift = d << sh;
`ifdef SHIFT_SEQ_SRA_EN
      2'b10: ref_shift = $unsigned($signed(d) >>> sh);
`endif
      default: ref_shift = d >> sh;
    endcase
  endfunction

  // Presents one request, checks latency (cycles from accept to first rspValid)
  // and result, holds rspReady low for rsp_stall cycles, then completes.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input int pre_stall, input int rsp_stall,
                        input logic [31:0] exp);
    int w;
    int n;
    int exp_lat;
    repeat (pre_stall) tick();
    reqValid = 1'b1;
    reqOp    = op;
    reqData  = d;
    reqShamt = sh;
    w = 0;
    while (!reqReady && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_req_ready"}, {31'd0, reqReady}, 32'd1);
    tick();
    reqValid = 1'b0;
    reqOp    = 2'($urandom);
    reqData  = $urandom;
    reqShamt = 5'($urandom);
    n = 1;
    while (!rspValid && n < 40) begin
      tick();
      n++;
    end
    exp_lat = 1 + (int'(sh) + 6) / 7;
    check({tag, "_latency"}, n, exp_lat);
    repeat (rsp_stall) tick();
    check({tag, "_data"}, rspData, exp);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    check({tag, "_idle_after"}, {30'd0, busy, rspValid}, 32'd0);
  endtask

  initial begin
    logic seen_rsp;
    logic [31:0] sra_exp;
    rstN     = 1'b0;
    reqValid = 1'b0;
    reqOp    = 2'b00;
    reqData  = 32'h0;
    reqShamt = 5'd0;
    rspReady = 1'b0;
    tick();
    check("reset_outputs", {28'd0, reqReady, rspValid, busy, 1'b0}, 32'h8);
    check("reset_rspdata", rspData, 32'h0);
    tick();
    rstN = 1'b1;
    tick();

    // 1: SLL by 31 takes five steps (7,7,7,7,3)
    run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 0, 0, 32'h8000_0000);

    // 2: zero shift goes straight to DONE
    reqValid = 1'b1; reqOp = 2'b01; reqData = 32'h8000_0000; reqShamt = 5'd0;
    tick();
    reqValid = 1'b0;
    check("sh0_valid", {30'd0, rspValid, busy}, 32'h3);
    check("sh0_req_ready", {31'd0, reqReady}, 32'd0);
    check("sh0_data", rspData, 32'h8000_0000);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;

    // 3: arithmetic shift build-dependent; reserved op is SRL
`ifdef SHIFT_SEQ_SRA_EN
    sra_exp = 32'hFFF0_0000;
`else
    sra_exp = 32'h00F0_0000;
`endif
    run_op("sra8", 2'b10, 32'hF000_0000, 5'd8, 1, 0, sra_exp);
    run_op("rsv8", 2'b11, 32'hF000_0000, 5'd8, 0, 0, 32'h00F0_0000);

    // 4: backpressure holds result stable
    reqValid = 1'b1; reqOp = 2'b01; reqData = 32'h1234_5678; reqShamt = 5'd4;
    tick();
    reqValid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rspValid}, 32'd1);
      check("bp_data", rspData, 32'h0123_4567);
      tick();
    end
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    check("bp_idle", {29'd0, reqReady, rspValid, busy}, 32'h4);
    check("bp_data_zero", rspData, 32'h0);

    // 5: reset in the middle of a shift aborts it
    reqValid = 1'b1; reqOp = 2'b00; reqData = 32'h0000_ABCD; reqShamt = 5'd20;
    tick();
    reqValid = 1'b0;
    tick();
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    rstN = 1'b0;
    #1;
    check("rst_mid_outputs", {29'd0, reqReady, rspValid, busy}, 32'h4);
    tick();
    rstN = 1'b1;
    seen_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen_rsp = seen_rsp | rspValid;
      tick();
    end
    check("rst_no_rsp", {31'd0, seen_rsp}, 32'd0);
    run_op("after_rst", 2'b00, 32'h0000_0001, 5'd1, 0, 0, 32'h0000_0002);

    // 6: random operations with random stalls
    for (int k = 0; k < 1000; k++) begin
      logic [1:0]  op;
      logic [31:0] d;
      logic [4:0]  sh;
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      sh = 5'($urandom_range(0, 31));
      run_op("rand", op, d, sh, $urandom_range(0, 2), $urandom_range(0, 3),
             ref_shift(op, d, sh));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
